// File: rtl/scan_rw_bank.sv
// scan_rw_bank: serial scan access to a bank of NumCh configuration channels.
// A shift register is loaded serially (LSB first) or in parallel from CfgIn,
// and committed to the CfgOut flops on SUpdate, optionally only when exactly
// L bits have been shifted since the last capture/update/reset.

// One channel of latched configuration; loads its slice of SR on commit.
module scan_rw_chan #(
   parameter int              PWidth = 4,
   parameter logic [PWidth-1:0] RstVal = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              commit,
   input  logic [PWidth-1:0] d,
   output logic [PWidth-1:0] q
);

   // channel configuration flop, reset to its slice of ResetValue
   always_ff @(posedge clk) begin
      if (rst)         q <= RstVal;
      else if (commit) q <= d;
   end

endmodule

module scan_rw_bank #(
   parameter int                       PWidth     = 4,
   parameter int                       NumCh      = 2,
   parameter int                       Mode       = 2,
   parameter int                       StrictLen  = 1,
   parameter logic [PWidth*NumCh-1:0]  ResetValue = '0
) (
   input  logic                      SClk,
   input  logic                      SReset,
   input  logic                      SEnable,
   input  logic                      SCapture,
   input  logic                      SUpdate,
   input  logic                      SIn,
   output logic                      SOut,
   input  logic [PWidth*NumCh-1:0]   CfgIn,
   output logic [PWidth*NumCh-1:0]   CfgOut,
   output logic                      UpdAck,
   output logic                      LenErr
);

   localparam int L  = PWidth * NumCh;
   localparam int CW = $clog2(L + 2);
   // exact-length target and the saturation value that marks an overrun
   localparam logic [CW-1:0] LenC   = CW'(L);
   localparam logic [CW-1:0] CntMax = CW'(L + 1);

   logic [L-1:0]  sr;
   logic [CW-1:0] cnt;
   logic          upd_ack;
   logic          len_err;

   logic          upd_go;   // SUpdate honoured in this mode
   logic          cap_go;   // SCapture honoured in this mode
   logic          len_ok;   // shift count allows a commit
   logic          commit;
   logic [L:0]    sr_ext;   // SIn prepended so the shift also works for L=1
   logic [L-1:0]  sr_sh;

   logic [NumCh-1:0][PWidth-1:0] sr_ch;
   logic [NumCh-1:0][PWidth-1:0] cfg_ch;

   // strobe qualification by access mode and length check
   always_comb begin
      upd_go = SUpdate && (Mode != 0);
      cap_go = SCapture && (Mode != 1);
      len_ok = (StrictLen == 0) || (cnt == LenC);
      commit = upd_go && len_ok;
      sr_ext = {SIn, sr};
      sr_sh  = sr_ext[L:1];
   end

   // shift register and shift counter; update > capture > shift
   always_ff @(posedge SClk) begin
      if (SReset) begin
         sr  <= '0;
         cnt <= '0;
      end else if (upd_go) begin
         cnt <= '0;
      end else if (cap_go) begin
         sr  <= CfgIn;
         cnt <= '0;
      end else if (SEnable) begin
         sr <= sr_sh;
         if (cnt != CntMax) cnt <= cnt + CW'(1);
      end
   end

   // commit acknowledge pulse and sticky length-error flag
   always_ff @(posedge SClk) begin
      if (SReset) begin
         upd_ack <= 1'b0;
         len_err <= 1'b0;
      end else begin
         upd_ack <= commit;
         if (upd_go && !len_ok) len_err <= 1'b1;
      end
   end

   assign sr_ch = sr;

   // CfgOut comes only from per-channel flops, never from SR directly
   for (genvar k = 0; k < NumCh; k++) begin : g_ch
      scan_rw_chan #(
         .PWidth (PWidth),
         .RstVal (ResetValue[k*PWidth +: PWidth])
      ) u_chan (
         .clk    (SClk),
         .rst    (SReset),
         .commit (commit),
         .d      (sr_ch[k]),
         .q      (cfg_ch[k])
      );
   end

   assign CfgOut = cfg_ch;
   assign SOut   = sr[0];
   assign UpdAck = upd_ack;
   assign LenErr = len_err;

endmodule
